prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Downstream consumer of the 32x32 tree multipliers (Wallace, Dadda, Cl32), which produce a 64-bit product P.
- Accepts a burst of `len` products over a valid/ready handshake and sums them into a wide accumulator.
- Presents the final sum with a sticky overflow flag on an output valid/ready handshake.
- Turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- PW, 64: product input width in bits (matches multiplier P).
- AW, 72: accumulator and result width in bits; must be >= PW.
- CW, 16: width of the burst length and of the internal counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a burst; sampled only in IDLE.
- len  input  CW  number of products in the burst; sampled with start.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block accepts in_prod this cycle.
- in_prod  input  PW  unsigned product from the multiplier.
- out_valid  output  1  out_acc/out_ovf are valid.
- out_ready  input  1  consumer takes the result.
- out_acc  output  AW  accumulated sum, modulo 2^AW.
- out_ovf  output  1  sticky: a carry out of bit AW-1 occurred during the burst.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and len!=0: acc<=0, ovf<=0, cnt<=len, next=ACCUM.
  - start=1 and len==0: acc<=0, ovf<=0, next=DONE. The result is 0 with ovf=0.
  - start=0: stay in IDLE.
- ACCUM:
  - in_ready=1 throughout.
  - A handshake is in_valid&&in_ready.
  - On each handshake: {carry,acc}<=acc+zero_extend(in_prod); ovf<=ovf|carry; cnt<=cnt-1.
  - Handshake with cnt==1: next=DONE.
  - in_valid=0: hold all state; gaps of any length are allowed.
- DONE:
  - out_valid=1, in_ready=0.
  - out_acc and out_ovf are stable until out_valid&&out_ready.
  - On that handshake: next=IDLE, out_valid deasserts the following cycle.
- Latency: out_valid rises on the first cycle after the clock edge that takes the last product.
- Throughput: one product per cycle in ACCUM.
- start is ignored outside IDLE; len is sampled only with an accepted start.
- start in the same cycle as the DONE handshake is ignored; a new burst needs start in IDLE.
- Arithmetic is unsigned. The sum wraps modulo 2^AW and ovf records any wrap.
- When AW>PW, in_prod is zero-extended.
- len=2^CW-1 is legal; cnt never underflows because ACCUM exits at cnt==1.
- in_prod is ignored whenever in_ready=0.
- Asserting rst_n low mid-burst clears everything immediately. A partial burst is discarded and never produces a result.

Decomposition:
- Shared package prod_accum_pkg holds:
  - the state enum (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2);
  - default width constants PW_DEF=64, AW_DEF=72, CW_DEF=16.
- No sub-module: the adder is a single expression.
- The multiplier (COMBINE64, COMBINE64_dadda or Cl32) is instantiated alongside prod_accum at the next level up, not inside it.

Test Plan:
- Basic burst: start, len=3, products 1, 2, 4 (multiplier A=1,B=1; A=2,B=1; A=2,B=2), each with in_valid=1 back-to-back -> out_valid on the cycle after the third handshake, out_acc=7, out_ovf=0, busy high from the cycle after start until the cycle after the out handshake.
- Gaps and backpressure: len=2, products 0xFFFF_FFFF and 0x1 with 3 idle cycles between them; hold out_ready=0 for 5 cycles -> out_acc=0x1_0000_0000 held stable, out_valid=1 throughout, in_ready=0 in DONE, a start pulse during DONE is ignored (busy stays high, next result unchanged).
- Overflow (AW=64 build): len=2, both products 0xFFFF_FFFF_FFFF_FFFF -> out_acc=0xFFFF_FFFF_FFFF_FFFE, out_ovf=1. A following burst with len=1, product 5 -> out_acc=5, out_ovf=0 (ovf cleared on start).
- Zero length: start with len=0 -> out_valid=1 on the next cycle, out_acc=0, out_ovf=0, in_ready never asserted.
- Reset mid-burst: len=4, accept 2 products (10, 20), pulse rst_n low for 1 cycle asynchronously -> all outputs 0 and state IDLE immediately. A new burst with len=1, product 3 -> out_acc=3.
- Max throughput: len=8, products 1..8 presented every cycle with in_valid=1 -> 8 handshakes in 8 consecutive cycles, out_acc=36, out_valid exactly one cycle after the eighth handshake.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
package prod_accum_pkg;

    localparam int unsigned PW_DEF = 64;
    localparam int unsigned AW_DEF = 72;
    localparam int unsigned CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/prod_accum_if.sv
// Burst control, product input and result output handshakes of prod_accum.
interface prod_accum_if
    import prod_accum_pkg::*;
#(
    parameter int unsigned PW = PW_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned CW = CW_DEF
);

    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_ovf;
    logic          busy;

    modport master (
        output start, len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, busy
    );

endinterface

// File: rtl/prod_accum.sv
// Sums a burst of unsigned multiplier products into a wide accumulator and
// presents the total with a sticky wrap flag.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int unsigned PW = PW_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    prod_accum_if.slave  bus
);

    localparam int unsigned SW = AW + 1;

    state_t        state;
    logic [AW-1:0] acc;
    logic          ovf;
    logic [CW-1:0] cnt;

    logic [PW-1:0] prod_c;
    logic [SW-1:0] sum_c;

    // Zero-extended add; the extra top bit is the carry out of the accumulator.
    assign prod_c = bus.in_prod;
    assign sum_c  = {1'b0, acc} + SW'(prod_c);

    // Burst sequencing and accumulation; in ACCUM in_ready is high, so
    // in_valid alone marks a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= bus.len;
                        state <= (bus.len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc <= sum_c[AW-1:0];
                        ovf <= ovf | sum_c[AW];
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decoded straight from registers; no input-to-output paths.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_acc   = acc;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: default 72-bit build plus a 64-bit build
// for the wrap case, checked against a queue of modelled results.
module tb_prod_accum;

    logic clk;
    logic rst_n;

    typedef struct packed {
        logic [71:0] acc;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [95:0] model_total;
    int          total;
    int          bad;
    int          hs;

    prod_accum_if #(.PW(64), .AW(72), .CW(16)) bus ();
    prod_accum_if #(.PW(64), .AW(64), .CW(16)) bus64 ();

    prod_accum #(.PW(64), .AW(72), .CW(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    prod_accum #(.PW(64), .AW(64), .CW(16)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        model_total = '0;
        step();
        bus.start = 1'b0;
    endtask

    // Present one product; leaves in_valid high so the caller can chain.
    task automatic send(input logic [63:0] p);
        int n;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("send_timeout", 80'(bus.in_ready), 80'(1));
        step();
        model_total = model_total + 96'(p);
    endtask

    task automatic push_model();
        e.acc = model_total[71:0];
        e.ovf = |model_total[95:72];
        sb.push_back(e);
    endtask

    task automatic collect(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step();
            n++;
        end
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, 80'(bus.out_valid), 80'(1));
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 80'(sb.size()), 80'(1));
            return;
        end
        e = sb.pop_front();
        check({tag, "_acc"}, 80'(bus.out_acc), 80'(e.acc));
        check({tag, "_ovf"}, 80'(bus.out_ovf), 80'(e.ovf));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 80'(bus.out_valid), 80'(0));
    endtask

    task automatic collect64(input string tag);
        int n;
        n = 0;
        while (!bus64.out_valid && n < 50) begin
            step();
            n++;
        end
        if (!bus64.out_valid || sb.size() == 0) begin
            check({tag, "_timeout"}, 80'(bus64.out_valid), 80'(1));
            return;
        end
        e = sb.pop_front();
        check({tag, "_acc"}, 80'(bus64.out_acc), 80'(e.acc));
        check({tag, "_ovf"}, 80'(bus64.out_ovf), 80'(e.ovf));
        bus64.out_ready = 1'b1;
        step();
        bus64.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 80'(bus64.out_valid), 80'(0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_total = '0;
        rst_n = 1'b1;
        bus.start = 1'b0;     bus.len = '0;     bus.in_valid = 1'b0;
        bus.in_prod = '0;     bus.out_ready = 1'b0;
        bus64.start = 1'b0;   bus64.len = '0;   bus64.in_valid = 1'b0;
        bus64.in_prod = '0;   bus64.out_ready = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_in_ready",  80'(bus.in_ready),  80'(0));
        check("rst_out_valid", 80'(bus.out_valid), 80'(0));
        check("rst_out_acc",   80'(bus.out_acc),   80'(0));
        check("rst_out_ovf",   80'(bus.out_ovf),   80'(0));
        check("rst_busy",      80'(bus.busy),      80'(0));
        rst_n = 1'b1;
        step();

        // Basic burst, back-to-back products
        start_burst(16'd3);
        check("basic_busy",     80'(bus.busy),     80'(1));
        check("basic_in_ready", 80'(bus.in_ready), 80'(1));
        send(64'd1);
        send(64'd2);
        check("basic_not_done", 80'(bus.out_valid), 80'(0));
        send(64'd4);
        bus.in_valid = 1'b0;
        check("basic_latency", 80'(bus.out_valid), 80'(1));
        push_model();
        collect("basic");
        check("basic_busy_end", 80'(bus.busy), 80'(0));

        // Gaps on input, backpressure on output, start ignored in DONE
        start_burst(16'd2);
        send(64'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("gap_in_ready", 80'(bus.in_ready), 80'(1));
            check("gap_no_out",   80'(bus.out_valid), 80'(0));
        end
        send(64'h1);
        bus.in_valid = 1'b0;
        push_model();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 80'(bus.out_valid), 80'(1));
            check("bp_in_ready",  80'(bus.in_ready),  80'(0));
            check("bp_out_acc",   80'(bus.out_acc),   80'(72'h1_0000_0000));
            if (i == 2) begin
                bus.start = 1'b1;
                bus.len   = 16'd5;
            end
            step();
            bus.start = 1'b0;
            check("bp_busy", 80'(bus.busy), 80'(1));
        end
        bus.start = 1'b1;
        bus.len   = 16'd5;
        collect("gap");
        bus.start = 1'b0;
        check("hs_start_ignored", 80'(bus.busy), 80'(0));
        step();
        check("hs_start_idle", 80'(bus.busy), 80'(0));

        // Zero-length burst
        start_burst(16'd0);
        push_model();
        check("zero_valid",    80'(bus.out_valid), 80'(1));
        check("zero_in_ready", 80'(bus.in_ready),  80'(0));
        collect("zero");

        // Wrap on the 64-bit build, then ovf cleared by the next start
        bus64.start = 1'b1;
        bus64.len   = 16'd2;
        step();
        bus64.start    = 1'b0;
        bus64.in_valid = 1'b1;
        bus64.in_prod  = 64'hFFFF_FFFF_FFFF_FFFF;
        check("ovf_in_ready", 80'(bus64.in_ready), 80'(1));
        step();
        step();
        bus64.in_valid = 1'b0;
        e.acc = 72'h00_FFFF_FFFF_FFFF_FFFE;
        e.ovf = 1'b1;
        sb.push_back(e);
        collect64("ovf");
        bus64.start = 1'b1;
        bus64.len   = 16'd1;
        step();
        bus64.start    = 1'b0;
        bus64.in_valid = 1'b1;
        bus64.in_prod  = 64'd5;
        step();
        bus64.in_valid = 1'b0;
        e.acc = 72'd5;
        e.ovf = 1'b0;
        sb.push_back(e);
        collect64("ovf_clear");

        // Asynchronous reset in the middle of a burst
        start_burst(16'd4);
        send(64'd10);
        send(64'd20);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      80'(bus.busy),      80'(0));
        check("mid_rst_in_ready",  80'(bus.in_ready),  80'(0));
        check("mid_rst_out_valid", 80'(bus.out_valid), 80'(0));
        check("mid_rst_out_acc",   80'(bus.out_acc),   80'(0));
        check("mid_rst_out_ovf",   80'(bus.out_ovf),   80'(0));
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle", 80'(bus.busy), 80'(0));
        start_burst(16'd1);
        send(64'd3);
        bus.in_valid = 1'b0;
        push_model();
        collect("post_rst");

        // Full-rate burst of 8
        start_burst(16'd8);
        hs = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_prod  = 64'(i);
            if (bus.in_ready) hs++;
            check("tput_no_early_out", 80'(bus.out_valid), 80'(0));
            step();
            model_total = model_total + 96'(i);
        end
        bus.in_valid = 1'b0;
        check("tput_handshakes", 80'(hs), 80'(8));
        check("tput_latency",    80'(bus.out_valid), 80'(1));
        push_model();
        collect("tput");

        check("sb_empty", 80'(sb.size()), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
